// File: rtl/axis_fir_reload_if.sv
// AXI-Stream channel bundle shared by the sample, coefficient and result ports of axis_fir_reload.
interface axis_fir_reload_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_fir_reload.sv
// Three-stage AXI-Stream FIR with full backpressure; define FIR_COEFF_RELOAD_EN to enable the
// shadow-bank coefficient reload port, otherwise coefficients are a fixed all-ones set.
module axis_fir_reload #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int N_TAPS      = 16
) (
  input  logic              clk,
  input  logic              rst,
  axis_fir_reload_if.slave  s_axis_data,
  axis_fir_reload_if.slave  s_axis_coeff,
  axis_fir_reload_if.master m_axis,
  output logic              coeff_err
);
  localparam int OUT_WIDTH  = DATA_WIDTH + COEFF_WIDTH + $clog2(N_TAPS);
  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
  localparam int CNT_WIDTH  = $clog2(N_TAPS);

  logic                          en;
  logic signed [DATA_WIDTH-1:0]  x        [N_TAPS];
  logic signed [COEFF_WIDTH-1:0] h_active [N_TAPS];
  logic signed [PROD_WIDTH-1:0]  p        [N_TAPS];
  logic signed [OUT_WIDTH-1:0]   acc;
  logic signed [OUT_WIDTH-1:0]   y;
  logic                          v0, l0, v1, l1, yv, yl;

  assign en                 = !yv || m_axis.tready;
  assign s_axis_data.tready = en;
  assign m_axis.tdata       = y;
  assign m_axis.tvalid      = yv;
  assign m_axis.tlast       = yl;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_TAPS; k++) x[k] <= '0;
      v0 <= 1'b0;
      l0 <= 1'b0;
    end else if (en) begin
      v0 <= s_axis_data.tvalid;
      l0 <= s_axis_data.tvalid && s_axis_data.tlast;
      if (s_axis_data.tvalid) begin
        x[0] <= s_axis_data.tdata;
        for (int unsigned k = 1; k < N_TAPS; k++) x[k] <= x[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_TAPS; k++) p[k] <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else if (en) begin
      for (int unsigned k = 0; k < N_TAPS; k++)
        p[k] <= PROD_WIDTH'(h_active[k]) * PROD_WIDTH'(x[k]);
      v1 <= v0;
      l1 <= l0;
    end
  end

  always_comb begin
    acc = '0;
    for (int unsigned k = 0; k < N_TAPS; k++) acc = acc + OUT_WIDTH'(p[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y  <= '0;
      yv <= 1'b0;
      yl <= 1'b0;
    end else if (en) begin
      y  <= acc;
      yv <= v1;
      yl <= l1;
    end
  end

`ifdef FIR_COEFF_RELOAD_EN
  typedef enum logic {LOAD, DRAIN} cstate_t;

  cstate_t                       state, state_n;
  logic [CNT_WIDTH-1:0]          cnt, cnt_n;
  logic signed [COEFF_WIDTH-1:0] shadow [N_TAPS];
  logic                          beat, wr, swap, err_n;

  assign s_axis_coeff.tready = !rst;
  assign beat                = s_axis_coeff.tvalid && !rst;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr      = 1'b0;
    swap    = 1'b0;
    err_n   = 1'b0;
    case (state)
      LOAD: begin
        if (beat) begin
          if (cnt == CNT_WIDTH'(N_TAPS - 1)) begin
            cnt_n = '0;
            if (s_axis_coeff.tlast) begin
              wr   = 1'b1;
              swap = 1'b1;
            end else begin
              err_n   = 1'b1;
              state_n = DRAIN;
            end
          end else if (s_axis_coeff.tlast) begin
            err_n = 1'b1;
            cnt_n = '0;
          end else begin
            wr    = 1'b1;
            cnt_n = cnt + CNT_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (beat && s_axis_coeff.tlast) begin
          state_n = LOAD;
          cnt_n   = '0;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  // The final beat bypasses shadow so the whole set lands in h_active on its acceptance edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      coeff_err <= 1'b0;
      for (int unsigned k = 0; k < N_TAPS; k++) begin
        shadow[k]   <= COEFF_WIDTH'(1);
        h_active[k] <= COEFF_WIDTH'(1);
      end
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      coeff_err <= err_n;
      if (wr) shadow[cnt] <= s_axis_coeff.tdata;
      if (swap) begin
        for (int unsigned k = 0; k < N_TAPS - 1; k++) h_active[k] <= shadow[k];
        h_active[N_TAPS-1] <= s_axis_coeff.tdata;
      end
    end
  end
`else
  logic unused_coeff;

  assign unused_coeff        = ^{s_axis_coeff.tdata, s_axis_coeff.tvalid, s_axis_coeff.tlast};
  assign s_axis_coeff.tready = 1'b0;
  assign coeff_err           = 1'b0;

  for (genvar g = 0; g < N_TAPS; g++) begin : g_unity
    assign h_active[g] = COEFF_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_axis_fir_reload.sv
// Scoreboard bench for axis_fir_reload: a reference FIR model queues expected outputs per accepted sample.
`timescale 1ns/1ps
module tb_axis_fir_reload;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NT = 16;
  localparam int OW = DW + CW + $clog2(NT);

  typedef struct {
    longint y;
    logic   last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coeff_err;

  always #5 clk = ~clk;

  axis_fir_reload_if #(.WIDTH(DW)) s_data ();
  axis_fir_reload_if #(.WIDTH(CW)) s_coeff ();
  axis_fir_reload_if #(.WIDTH(OW)) m_out ();

  axis_fir_reload #(
    .DATA_WIDTH (DW),
    .COEFF_WIDTH(CW),
    .N_TAPS     (NT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis_data (s_data),
    .s_axis_coeff(s_coeff),
    .m_axis      (m_out),
    .coeff_err   (coeff_err)
  );

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  exp_t   sbq[$];
  exp_t   e;
  longint hist[NT];
  longint mh[NT];
  longint newh[NT];
  longint last_y;
  bit     bp_mode = 1'b0;
  bit     arm = 1'b0;
  bit     stalled = 1'b0;
  int     first_valid_cyc;
  int     last_acc_cyc;
  logic signed [OW-1:0] got;
  logic [OW-1:0]        held_d;
  logic                 held_l;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    m_out.tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (arm && m_out.tvalid) begin
        first_valid_cyc = cyc;
        arm = 1'b0;
      end
      if (stalled) begin
        checks++;
        if (m_out.tvalid !== 1'b1 || m_out.tdata !== held_d || m_out.tlast !== held_l) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   m_out.tvalid, m_out.tdata, m_out.tlast, held_d, held_l);
        end
      end
      stalled = m_out.tvalid && !m_out.tready;
      held_d  = m_out.tdata;
      held_l  = m_out.tlast;
      if (m_out.tvalid && m_out.tready) begin
        got = m_out.tdata;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %0d, want no output", got);
        end else begin
          e = sbq.pop_front();
          if (longint'(got) !== e.y || m_out.tlast !== e.last) begin
            errors++;
            $display("FAIL output: got y=%0d last=%b, want y=%0d last=%b", got, m_out.tlast, e.y, e.last);
          end
        end
        last_y = longint'(got);
      end
    end else begin
      stalled = 1'b0;
    end
  end

  function automatic void model_push(input longint d, input logic last);
    longint y = 0;
    for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
    for (int k = 0; k < NT; k++) y += mh[k] * hist[k];
    sbq.push_back('{y, last});
  endfunction

  task automatic send_sample(input longint d, input logic last);
    int n = 0;
    s_data.tdata  = DW'(d);
    s_data.tvalid = 1'b1;
    s_data.tlast  = last;
    @(negedge clk);
    while (!s_data.tready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL data_accept_timeout: tready=%b, want 1", s_data.tready);
    end else begin
      last_acc_cyc = cyc;
      model_push(d, last);
    end
    @(posedge clk);
    #1;
    s_data.tvalid = 1'b0;
    s_data.tlast  = 1'b0;
  endtask

  task automatic send_coeff(input longint c, input logic last);
    int n = 0;
    s_coeff.tdata  = CW'(c);
    s_coeff.tvalid = 1'b1;
    s_coeff.tlast  = last;
    @(negedge clk);
    while (!s_coeff.tready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL coeff_accept_timeout: tready=%b, want 1", s_coeff.tready);
    end
    @(posedge clk);
    #1;
    s_coeff.tvalid = 1'b0;
    s_coeff.tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: outstanding=%0d, want 0", name, sbq.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic impulse(input longint amp, input string name);
    send_sample(amp, 1'b0);
    for (int k = 0; k < NT + 2; k++) send_sample(0, k == NT + 1);
    wait_drain(name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_data.tvalid  = 1'b0;
    s_data.tlast   = 1'b0;
    s_coeff.tvalid = 1'b0;
    s_coeff.tlast  = 1'b0;
    sbq.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (m_out.tvalid !== 1'b0 || m_out.tdata !== '0 || m_out.tlast !== 1'b0 ||
          coeff_err !== 1'b0 || s_coeff.tready !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got v=%b d=%h l=%b err=%b crdy=%b, want all 0",
                 m_out.tvalid, m_out.tdata, m_out.tlast, coeff_err, s_coeff.tready);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < NT; k++) begin
      hist[k] = 0;
      mh[k]   = 1;
    end
    #1;
    checks++;
    if (s_data.tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_data_ready: got %b, want 1", s_data.tready);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_impulse();
    int a0;
    arm = 1'b1;
    send_sample(1, 1'b0);
    a0 = last_acc_cyc;
    for (int k = 0; k < 20; k++) send_sample(0, k == 19);
    wait_drain("impulse");
    checks++;
    if (arm || first_valid_cyc - a0 !== 3) begin
      errors++;
      $display("FAIL latency: got %0d cycles (armed=%b), want 3", first_valid_cyc - a0, arm);
    end
  endtask

`ifdef FIR_COEFF_RELOAD_EN
  task automatic load_coeffs();
    for (int k = 0; k < NT; k++) send_coeff(newh[k], k == NT - 1);
    mh = newh;
    checks++;
    if (coeff_err !== 1'b0) begin
      errors++;
      $display("FAIL load_err: got %b, want 0", coeff_err);
    end
  endtask

  task automatic test_reload();
    for (int k = 0; k < NT; k++) newh[k] = k + 1;
    for (int k = 0; k < NT - 1; k++) send_coeff(newh[k], 1'b0);
    mh = newh;
    fork
      send_coeff(newh[NT-1], 1'b1);
      send_sample(5, 1'b0);
    join
    for (int k = 0; k < NT; k++) send_sample(0, 1'b0);
    wait_drain("same_edge");
    impulse(2, "reload_impulse");
    for (int k = 0; k < 24; k++) send_sample(1, k == 23);
    wait_drain("reload_step");
    checks++;
    if (last_y !== 136) begin
      errors++;
      $display("FAIL step_final: got %0d, want 136", last_y);
    end
  endtask

  task automatic test_malformed();
    for (int k = 0; k < 5; k++) send_coeff(100 + k, k == 4);
    checks++;
    if (coeff_err !== 1'b1) begin
      errors++;
      $display("FAIL short_err: got %b, want 1", coeff_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (coeff_err !== 1'b0) begin
      errors++;
      $display("FAIL short_err_pulse: got %b, want 0", coeff_err);
    end
    impulse(3, "after_short");
    for (int k = 0; k < NT + 1; k++) begin
      send_coeff(-7, k == NT);
      if (k >= NT - 1) begin
        checks++;
        if (coeff_err !== (k == NT - 1)) begin
          errors++;
          $display("FAIL long_err beat %0d: got %b, want %b", k + 1, coeff_err, k == NT - 1);
        end
      end
    end
    impulse(3, "after_long");
    for (int k = 0; k < NT; k++) newh[k] = (k % 2 == 1) ? -(k + 1) : 3 * k;
    load_coeffs();
    impulse(1, "after_good");
  endtask
`else
  task automatic test_coeff_ignored();
    for (int k = 0; k < 20; k++) begin
      s_coeff.tdata  = CW'(k * 3);
      s_coeff.tvalid = 1'b1;
      s_coeff.tlast  = (k % 5 == 4);
      @(negedge clk);
      checks++;
      if (s_coeff.tready !== 1'b0 || coeff_err !== 1'b0) begin
        errors++;
        $display("FAIL coeff_ignored: got rdy=%b err=%b, want 0 0", s_coeff.tready, coeff_err);
      end
      @(posedge clk);
      #1;
    end
    s_coeff.tvalid = 1'b0;
    s_coeff.tlast  = 1'b0;
    impulse(1, "fixed_ones");
  endtask
`endif

  task automatic test_back_to_back();
    int a0;
    send_sample(11, 1'b0);
    a0 = last_acc_cyc;
    for (int k = 1; k < 32; k++) send_sample(k * 37 - 500, k == 31);
    checks++;
    if (last_acc_cyc - a0 !== 31) begin
      errors++;
      $display("FAIL throughput: got %0d cycles for 32 samples, want 31", last_acc_cyc - a0);
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_extremes();
    longint want;
`ifdef FIR_COEFF_RELOAD_EN
    for (int k = 0; k < NT; k++) newh[k] = -32768;
    load_coeffs();
    want = 64'sd1 <<< 34;
`else
    want = -524288;
`endif
    for (int k = 0; k < NT + 4; k++) send_sample(-32768, k == NT + 3);
    wait_drain("extremes");
    checks++;
    if (last_y !== want) begin
      errors++;
      $display("FAIL extreme_sum: got %0d, want %0d", last_y, want);
    end
  endtask

  task automatic test_backpressure();
    bp_mode = 1'b1;
    for (int k = 0; k < 100; k++)
      send_sample(longint'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 7) == 0);
    wait_drain("backpressure");
    bp_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
`ifdef FIR_COEFF_RELOAD_EN
    for (int k = 0; k < 8; k++) send_coeff(7, 1'b0);
`endif
    for (int k = 0; k < 6; k++) send_sample(1000 + k, 1'b0);
    do_reset();
    impulse(1, "post_reset");
  endtask

  initial begin
    s_data.tdata   = '0;
    s_data.tvalid  = 1'b0;
    s_data.tlast   = 1'b0;
    s_coeff.tdata  = '0;
    s_coeff.tvalid = 1'b0;
    s_coeff.tlast  = 1'b0;
    m_out.tready   = 1'b1;
    test_reset();
    test_impulse();
`ifdef FIR_COEFF_RELOAD_EN
    test_reload();
`else
    test_coeff_ignored();
`endif
    test_back_to_back();
    test_extremes();
    test_backpressure();
`ifdef FIR_COEFF_RELOAD_EN
    test_malformed();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
